// File: rtl/car_draw_control_pkg.sv
// Shared types and default geometry for the car drawing controller and its datapath.
package car_draw_control_pkg;

    typedef logic [7:0] coord_t;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StDrawBg,
        StDrawCar,
        StWait,
        StErase,
        StDrive
    } state_e;

    localparam int unsigned ScreenW       = 160;
    localparam int unsigned ScreenH       = 120;
    localparam int unsigned CarW          = 8;
    localparam int unsigned CarH          = 8;
    localparam int unsigned CarY0         = 100;
    localparam int unsigned Step          = 2;
    localparam int unsigned FrameDiv      = 833333;
    localparam int unsigned FramesPerStep = 4;

    // 9-bit sum keeps the right move from wrapping before the clamp.
    function automatic coord_t drive_x(coord_t x, logic left, logic right, coord_t step,
                                       coord_t max_x);
        logic [8:0] sum;
        sum     = {1'b0, x} + {1'b0, step};
        drive_x = x;
        if (left && !right) begin
            drive_x = (x < step) ? '0 : x - step;
        end else if (right && !left) begin
            drive_x = (sum > {1'b0, max_x}) ? max_x : sum[7:0];
        end
    endfunction

endpackage

// File: rtl/car_draw_control_if.sv
// Command/status bundle between the drawing controller and the pixel datapath.
interface car_draw_control_if;
    logic                        start;
    logic                        key_left;
    logic                        key_right;
    logic                        resetsignal;
    logic                        draw_bg;
    logic                        draw_car;
    logic                        erase;
    logic                        drive;
    logic                        plot;
    logic                        inc;
    logic                        busy;
    car_draw_control_pkg::coord_t car_x;
    car_draw_control_pkg::coord_t car_y;

    modport master (
        input  start, key_left, key_right,
        output resetsignal, draw_bg, draw_car, erase, drive, plot, inc, busy, car_x, car_y
    );

    modport slave (
        output start, key_left, key_right,
        input  resetsignal, draw_bg, draw_car, erase, drive, plot, inc, busy, car_x, car_y
    );
endinterface

// File: rtl/car_draw_control_raster_scan_counter.sv
// Column/row scan over a runtime-sized rectangle; inc marks the last column, done the last pixel.
module raster_scan_counter
    import car_draw_control_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   clear,
    input  logic   enable,
    input  coord_t width,
    input  coord_t height,
    output logic   inc,
    output logic   done
);

    coord_t col_q;
    coord_t row_q;

    assign inc  = (col_q == width - 8'd1);
    assign done = inc && (row_q == height - 8'd1);

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            col_q <= '0;
            row_q <= '0;
        end else if (enable) begin
            if (inc) begin
                col_q <= '0;
                row_q <= row_q + 8'd1;
            end else begin
                col_q <= col_q + 8'd1;
            end
        end
    end

endmodule

// File: rtl/car_draw_control.sv
// Control FSM sequencing background fill, car draw/erase and paced car movement.
module car_draw_control
    import car_draw_control_pkg::*;
#(
    parameter int unsigned SCREEN_W        = ScreenW,
    parameter int unsigned SCREEN_H        = ScreenH,
    parameter int unsigned CAR_W           = CarW,
    parameter int unsigned CAR_H           = CarH,
    parameter int unsigned CAR_Y0          = CarY0,
    parameter int unsigned STEP            = Step,
    parameter int unsigned FRAME_DIV       = FrameDiv,
    parameter int unsigned FRAMES_PER_STEP = FramesPerStep
) (
    input logic                 clock,
    input logic                 reset,
    car_draw_control_if.master  bus
);

    localparam int unsigned DivW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned FrmW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [DivW-1:0] DivLast = DivW'(FRAME_DIV - 1);
    localparam logic [FrmW-1:0] FrmLast = FrmW'(FRAMES_PER_STEP - 1);
    localparam coord_t          MaxX    = coord_t'(SCREEN_W - CAR_W);
    localparam coord_t          StartX  = coord_t'((SCREEN_W - CAR_W) / 2);

    state_e          state_q, state_d;
    coord_t          car_x_q, car_x_d;
    logic [DivW-1:0] div_q;
    logic [FrmW-1:0] frm_q, frm_d;
    logic            tick, step_due;
    logic            is_draw, scan_clear, scan_inc, scan_done;
    coord_t          scan_w, scan_h;

    assign is_draw    = (state_q == StDrawBg) || (state_q == StDrawCar) || (state_q == StErase);
    assign scan_w     = (state_q == StDrawBg) ? coord_t'(SCREEN_W) : coord_t'(CAR_W);
    assign scan_h     = (state_q == StDrawBg) ? coord_t'(SCREEN_H) : coord_t'(CAR_H);
    // Clearing on done lets back-to-back draw states start from pixel 0 with no gap.
    assign scan_clear = !is_draw || scan_done;

    raster_scan_counter u_scan (
        .clock  (clock),
        .reset  (reset),
        .clear  (scan_clear),
        .enable (is_draw),
        .width  (scan_w),
        .height (scan_h),
        .inc    (scan_inc),
        .done   (scan_done)
    );

    assign tick     = (div_q == DivLast);
    assign step_due = (state_q == StWait) && tick && (frm_q == FrmLast);

    always_comb begin
        frm_d = frm_q;
        if (state_q == StWait && tick) begin
            frm_d = (frm_q == FrmLast) ? '0 : frm_q + 1'b1;
        end
    end

    assign car_x_d = (state_q == StDrive)
        ? drive_x(car_x_q, bus.key_left, bus.key_right, coord_t'(STEP), MaxX) : car_x_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
            car_x_q <= StartX;
            div_q   <= '0;
            frm_q   <= '0;
        end else begin
            state_q <= state_d;
            car_x_q <= car_x_d;
            div_q   <= tick ? '0 : div_q + 1'b1;
            frm_q   <= frm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (bus.start) state_d = StClear;
            StClear:   state_d = StDrawBg;
            StDrawBg:  if (scan_done) state_d = StDrawCar;
            StDrawCar: if (scan_done) state_d = StWait;
            StWait:    if (step_due) state_d = StErase;
            StErase:   if (scan_done) state_d = StDrive;
            StDrive:   state_d = StDrawCar;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.resetsignal = 1'b0;
        bus.draw_bg     = 1'b0;
        bus.draw_car    = 1'b0;
        bus.erase       = 1'b0;
        bus.drive       = 1'b0;
        bus.plot        = 1'b0;
        bus.inc         = 1'b0;
        bus.busy        = (state_q != StIdle);
        case (state_q)
            StClear:   bus.resetsignal = 1'b1;
            StDrawBg:  bus.draw_bg = 1'b1;
            StDrawCar: bus.draw_car = 1'b1;
            StErase:   bus.erase = 1'b1;
            StDrive:   bus.drive = 1'b1;
            default:   ;
        endcase
        if (is_draw) begin
            bus.plot = 1'b1;
            bus.inc  = scan_inc;
        end
    end

    assign bus.car_x = car_x_q;
    assign bus.car_y = coord_t'(CAR_Y0);

endmodule

// File: tb/tb_car_draw_control.sv
// Directed bench for car_draw_control at reduced geometry (8x4 screen, 2x2 car).
module tb_car_draw_control;

    logic clock;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    car_draw_control_if bus ();

    car_draw_control #(
        .SCREEN_W        (8),
        .SCREEN_H        (4),
        .CAR_W           (2),
        .CAR_H           (2),
        .CAR_Y0          (2),
        .STEP            (1),
        .FRAME_DIV       (3),
        .FRAMES_PER_STEP (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {bus.resetsignal, bus.draw_bg, bus.draw_car, bus.erase, bus.drive, bus.plot,
                bus.inc};
    endfunction

    function automatic logic sel_strobe(input int sel);
        case (sel)
            0:       return bus.draw_bg;
            1:       return bus.draw_car;
            default: return bus.erase;
        endcase
    endfunction

    // Called on the first cycle of a draw state; returns on the first cycle after it.
    task automatic scan_measure(input int sel, output int n, output int plots,
                                output logic [31:0] incmask);
        n       = 0;
        plots   = 0;
        incmask = '0;
        while (sel_strobe(sel) && n < 100) begin
            n++;
            if (bus.plot) plots++;
            if (bus.inc && n <= 32) incmask = incmask | (32'd1 << (n - 1));
            @(negedge clock);
        end
    endtask

    task automatic run_frame(output int x);
        int k = 0;
        while (!bus.drive && k < 200) begin
            k++;
            @(negedge clock);
        end
        check_eq("drive_seen", {31'd0, bus.drive}, 32'd1);
        @(negedge clock);
        check_eq("drive_next_draw_car", {31'd0, bus.draw_car}, 32'd1);
        x = int'(bus.car_x);
    endtask

    initial begin
        int          n, plots, wait_n, wait_bad, x;
        logic [31:0] incmask;
        int          right_exp[4] = '{4, 5, 6, 6};

        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.key_left  = 1'b0;
        bus.key_right = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_strobes", {25'd0, strobes()}, 32'd0);
        check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("rst_car_x", {24'd0, bus.car_x}, 32'd3);
        check_eq("rst_car_y", {24'd0, bus.car_y}, 32'd2);

        reset = 1'b1;
        @(negedge clock);
        check_eq("idle_hold_busy", {31'd0, bus.busy}, 32'd0);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        check_eq("clear_pulse", {25'd0, strobes()}, 32'h40);
        check_eq("clear_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clock);
        check_eq("clear_once", {31'd0, bus.resetsignal}, 32'd0);

        scan_measure(0, n, plots, incmask);
        check_eq("bg_len", n, 32);
        check_eq("bg_plots", plots, 32);
        check_eq("bg_inc", incmask, 32'h8080_8080);

        check_eq("car_x_init", {24'd0, bus.car_x}, 32'd3);
        check_eq("car_y_init", {24'd0, bus.car_y}, 32'd2);
        scan_measure(1, n, plots, incmask);
        check_eq("car_len", n, 4);
        check_eq("car_plots", plots, 4);
        check_eq("car_inc", incmask, 32'h0000_000A);

        // start held through WAIT must not restart the sequence.
        bus.start = 1'b1;
        wait_n    = 0;
        wait_bad  = 0;
        while (!bus.erase && wait_n < 50) begin
            wait_n++;
            if (strobes() != 7'd0 || !bus.busy) wait_bad++;
            @(negedge clock);
        end
        bus.start = 1'b0;
        check_eq("wait_len_in_4_to_6", {31'd0, (wait_n >= 4 && wait_n <= 6)}, 32'd1);
        check_eq("wait_quiet", wait_bad, 0);

        scan_measure(2, n, plots, incmask);
        check_eq("erase_len", n, 4);
        check_eq("erase_plots", plots, 4);
        check_eq("erase_inc", incmask, 32'h0000_000A);
        check_eq("drive_pulse", {25'd0, strobes()}, 32'h04);
        @(negedge clock);
        check_eq("drive_one_cycle", {30'd0, bus.drive, bus.draw_car}, 32'd1);
        check_eq("drive_none", {24'd0, bus.car_x}, 32'd3);

        bus.key_right = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_frame(x);
            check_eq("drive_right", x, right_exp[i]);
        end

        bus.key_left = 1'b1;
        run_frame(x);
        check_eq("drive_both", x, 6);

        bus.key_right = 1'b0;
        for (int i = 0; i < 7; i++) begin
            run_frame(x);
            check_eq("drive_left", x, (i < 6) ? 5 - i : 0);
        end
        bus.key_left = 1'b0;

        reset = 1'b0;
        @(negedge clock);
        check_eq("rst_run_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("rst_run_car_x", {24'd0, bus.car_x}, 32'd3);
        check_eq("rst_run_strobes", {25'd0, strobes()}, 32'd0);

        reset     = 1'b1;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        repeat (12) @(negedge clock);
        check_eq("bg_mid_pixel13", {25'd0, strobes()}, 32'h22);
        reset = 1'b0;
        @(negedge clock);
        check_eq("rst_mid_strobes", {25'd0, strobes()}, 32'd0);
        check_eq("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("rst_mid_car_x", {24'd0, bus.car_x}, 32'd3);

        reset = 1'b1;
        @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        check_eq("restart_clear", {31'd0, bus.resetsignal}, 32'd1);
        @(negedge clock);
        scan_measure(0, n, plots, incmask);
        check_eq("restart_bg_len", n, 32);
        check_eq("restart_bg_inc", incmask, 32'h8080_8080);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/car_draw_control.md
Name: car_draw_control

Overview:
- Control FSM that acts as the initiator for the pixel-drawing datapath.
- Sequences the datapath commands: draw_bg, draw_car, erase, drive, resetsignal, plot and inc.
- Owns the pixel-scan counters, which generate row-advance and done conditions, and a frame-rate divider that paces car movement.
- Holds the car position and outputs it as the base point (car_x, car_y) for the datapath's xout/yout computation.

Parameters:
- SCREEN_W, 160, background width in pixels
- SCREEN_H, 120, background height in pixels
- CAR_W, 8, car sprite width
- CAR_H, 8, car sprite height
- CAR_Y0, 100, fixed car row
- STEP, 2, pixels moved per drive step
- FRAME_DIV, 833333, clock cycles per frame tick (50 MHz / 60)
- FRAMES_PER_STEP, 4, frame ticks waited between moves

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-low
- start  in  1  level/pulse; begins the sequence from IDLE
- key_left  in  1  move-left request, sampled in DRIVE
- key_right  in  1  move-right request, sampled in DRIVE
- resetsignal  out  1  datapath clear strobe
- draw_bg  out  1  background fill active
- draw_car  out  1  car sprite draw active
- erase  out  1  car erase active
- drive  out  1  position-update cycle
- plot  out  1  pixel write enable
- inc  out  1  last column of current row; datapath advances y and zeroes x
- car_x  out  8  car base x
- car_y  out  8  car base y
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: clock clock. reset is synchronous, active-low. Reset is honoured in any state, including mid-scan.
- Reset values:
  - state=IDLE.
  - All strobes 0, busy=0.
  - car_x=(SCREEN_W-CAR_W)/2 (76 at defaults), car_y=CAR_Y0.
  - Scan counters 0, frame divider 0, frame count 0.
- Output style: Moore outputs decoded from the registered state and counters. Each strobe is valid in the same cycle its state is entered.
- States:
  - IDLE: start=1 -> CLEAR.
  - CLEAR: resetsignal=1 for exactly 1 cycle -> DRAW_BG.
  - DRAW_BG: scan SCREEN_W x SCREEN_H. plot=1 every cycle. At col==W-1 && row==H-1 -> DRAW_CAR.
  - DRAW_CAR: scan CAR_W x CAR_H with plot=1. At the final pixel -> WAIT.
  - WAIT: no strobes. Count frame ticks. When the FRAMES_PER_STEP-th tick is seen -> ERASE, and the frame count clears.
  - ERASE: scan CAR_W x CAR_H with plot=1 and erase=1 -> DRIVE.
  - DRIVE: drive=1 for 1 cycle. Update car_x -> DRAW_CAR.
- Scan rules:
  - col counts 0..W-1. At W-1, col returns to 0 and row increments.
  - inc=1 exactly on cycles where col==W-1, including the final pixel.
  - Each draw state lasts exactly W*H cycles.
  - Counters zero on every entry into a draw state.
  - The final pixel is plotted in its own cycle. There is no extra idle cycle between a draw state and its successor.
- Frame divider:
  - Free-running 0..FRAME_DIV-1. tick=1 when the count is FRAME_DIV-1.
  - Ticks outside WAIT are ignored.
  - The width of both the divider and the frame counter is ceil(log2(...)).
- Drive arithmetic (keys sampled in the DRIVE cycle):
  - left only: car_x = (car_x < STEP) ? 0 : car_x-STEP.
  - right only: car_x = min(car_x+STEP, SCREEN_W-CAR_W). Compute with 9-bit intermediate to avoid wrap.
  - both or neither: car_x unchanged.
  - car_y never changes.
- start outside IDLE: ignored. There is no restart except via reset.

Decomposition:
- Shared package:
  - State enum: IDLE, CLEAR, DRAW_BG, DRAW_CAR, WAIT, ERASE, DRIVE.
  - Screen/car size constants, also used by the datapath.
  - 8-bit coordinate typedef.
- One natural sub-module: raster_scan_counter.
  - Parameterised by runtime width/height inputs.
  - Ports: clear, enable, inc, done.
  - Instantiated once and shared by all draw states.

Test Plan:
Small parameters for all scenarios: SCREEN 8x4, CAR 2x2, STEP 1, FRAME_DIV 3, FRAMES_PER_STEP 2, CAR_Y0 2.
- Reset then start pulse:
  - resetsignal high for 1 cycle.
  - DRAW_BG gives plot high for exactly 32 cycles, with inc high on cycles 8, 16, 24, 32.
  - DRAW_CAR gives 4 plot cycles, with inc on cycles 2 and 4.
  - car_x=3, car_y=2.
- WAIT pacing: after DRAW_CAR, ERASE is entered after the 2nd tick, i.e. no later than 6 cycles after WAIT entry. erase and plot are high for 4 cycles, then drive is high for 1 cycle.
- Drive clamps:
  - key_right held: car_x goes 3 -> 4 -> 5 -> 6 -> 6 (saturates at SCREEN_W-CAR_W=6).
  - key_left held: car_x goes 6 -> ... -> 0 -> 0.
- Both keys pressed in DRIVE: car_x unchanged, and the sequence proceeds to DRAW_CAR.
- Reset mid DRAW_BG at pixel 13: the next cycle shows state IDLE, all strobes 0, car_x=3. A subsequent start restarts a full 32-cycle fill.
- start held high while in WAIT: no effect. resetsignal never reasserts.
